// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter unit for the pipelined core.
// Holds the PC, performs the sequential increment, applies resolve-stage jump
// redirects, buffers a redirect that arrives during a stall, and drives a
// timed flush window to the fetch/decode registers.
// Optional build macro: PC_REDIRECT_COUNT_EN adds a saturating redirect_count.

`ifndef INSTR_JUMP
`define INSTR_JUMP 5'd2
`endif

module pc_sequencer #(
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned           INSTR_BYTES  = 4,
  parameter int unsigned           FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  resolve_valid,
  input  logic [4:0]            instr_type,
  input  logic [ADDR_WIDTH-1:0] jump_condition,
  input  logic [ADDR_WIDTH-1:0] jump_address,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  pc_valid,
  output logic                  flush,
  output logic                  redirect_pending
`ifdef PC_REDIRECT_COUNT_EN
  ,
  output logic [31:0]           redirect_count
`endif
);

  localparam logic [ADDR_WIDTH-1:0] INCR       = ADDR_WIDTH'(INSTR_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(INSTR_BYTES - 1));
  localparam logic [ADDR_WIDTH-1:0] COND_TAKEN = ADDR_WIDTH'(1);
  localparam logic [3:0]            FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] pend_q, pend_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  pc_valid_q, pc_valid_d;
  logic                  flush_q, flush_d;
  logic                  pending_q, pending_d;
  logic                  redirect_apply;

  logic                  taken;
  logic [ADDR_WIDTH-1:0] target;

  // Jump decision and aligned target; the condition must be exactly 1 over the full width.
  always_comb begin
    taken  = resolve_valid && (instr_type == `INSTR_JUMP) && (jump_condition == COND_TAKEN);
    target = jump_address & ALIGN_MASK;
  end

  // Next-state, next-PC and registered-output decode.
  // A redirect always passes through FLUSH, even when FLUSH_CYCLES is 1, so the
  // target is never consumed by fetch while flush is still asserted.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    pend_d         = pend_q;
    cnt_d          = cnt_q;
    redirect_apply = 1'b0;

    unique case (state_q)
      BOOT: begin
        // First fetch uses the reset vector unchanged.
        state_d = RUN;
      end
      RUN: begin
        if (taken) begin
          if (!stall) begin
            pc_d           = target;
            cnt_d          = FLUSH_LOAD;
            state_d        = FLUSH;
            redirect_apply = 1'b1;
          end else begin
            pend_d  = target;
            state_d = HOLD;
          end
        end else if (!stall) begin
          pc_d = pc_q + INCR;
        end
      end
      HOLD: begin
        // Younger taken events are ignored; the buffered jump is older.
        if (!stall) begin
          pc_d           = pend_q;
          cnt_d          = FLUSH_LOAD;
          state_d        = FLUSH;
          redirect_apply = 1'b1;
        end
      end
      FLUSH: begin
        // Wrong-path jumps are ignored; the window only advances when unstalled.
        if (!stall) begin
          if (cnt_q == 4'd0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase

    pc_valid_d = (state_d == RUN) || (state_d == HOLD);
    flush_d    = (state_d == FLUSH);
    pending_d  = (state_d == HOLD);
  end

  // State, PC and output registers; reset discards any buffered redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      pend_q     <= RESET_VECTOR;
      cnt_q      <= 4'd0;
      pc_valid_q <= 1'b0;
      flush_q    <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      pc_valid_q <= pc_valid_d;
      flush_q    <= flush_d;
      pending_q  <= pending_d;
    end
  end

  assign pc               = pc_q;
  assign pc_valid         = pc_valid_q;
  assign flush            = flush_q;
  assign redirect_pending = pending_q;

`ifdef PC_REDIRECT_COUNT_EN
  logic [31:0] rcount_q, rcount_d;

  // Saturating count of redirects actually loaded into the PC.
  always_comb begin
    rcount_d = rcount_q;
    if (redirect_apply && (rcount_q != 32'hFFFF_FFFF)) begin
      rcount_d = rcount_q + 32'd1;
    end
  end

  // Redirect counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcount_q <= 32'd0;
    end else begin
      rcount_q <= rcount_d;
    end
  end

  assign redirect_count = rcount_q;
`else
  logic unused_redirect_apply;
  assign unused_redirect_apply = redirect_apply;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a 32-bit and an 8-bit instance share
// stimulus and are compared every cycle against a behavioural model.

`ifndef INSTR_JUMP
`define INSTR_JUMP 5'd2
`endif

module tb_pc_sequencer;

  localparam int IB = 4;
  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        rv = 1'b0;
  logic [4:0]  itype = 5'd0;
  logic [31:0] jcond = 32'd0;
  logic [31:0] jaddr = 32'd0;

  logic [31:0] pc32;
  logic [7:0]  pc8;
  logic        valid32, valid8, flush32, flush8, pend32, pend8;
`ifdef PC_REDIRECT_COUNT_EN
  logic [31:0] cnt32, cnt8;
`endif

  always #5 clk = ~clk;

  pc_sequencer #(
    .ADDR_WIDTH(32), .RESET_VECTOR(32'h0), .INSTR_BYTES(IB), .FLUSH_CYCLES(FC)
  ) u_dut32 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .resolve_valid(rv),
    .instr_type(itype), .jump_condition(jcond), .jump_address(jaddr),
    .pc(pc32), .pc_valid(valid32), .flush(flush32), .redirect_pending(pend32)
`ifdef PC_REDIRECT_COUNT_EN
    , .redirect_count(cnt32)
`endif
  );

  pc_sequencer #(
    .ADDR_WIDTH(8), .RESET_VECTOR(8'h0), .INSTR_BYTES(IB), .FLUSH_CYCLES(FC)
  ) u_dut8 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .resolve_valid(rv),
    .instr_type(itype), .jump_condition(jcond[7:0]), .jump_address(jaddr[7:0]),
    .pc(pc8), .pc_valid(valid8), .flush(flush8), .redirect_pending(pend8)
`ifdef PC_REDIRECT_COUNT_EN
    , .redirect_count(cnt8)
`endif
  );

  // Behavioural model: a boot flag, remaining flush cycles, a one-deep
  // pending slot and the PC value.
  typedef struct {
    bit          booted;
    int          flush_left;
    bit          has_pend;
    logic [31:0] pend;
    logic [31:0] pc;
    int unsigned count;
  } mdl_t;

  mdl_t m32, m8;
  int   n_assert = 0;
  int   n_fail = 0;
  int   n_cyc = 0;

  function automatic mdl_t mreset();
    mdl_t m;
    m.booted     = 1'b0;
    m.flush_left = 0;
    m.has_pend   = 1'b0;
    m.pend       = 32'd0;
    m.pc         = 32'd0;
    m.count      = 0;
    return m;
  endfunction

  function automatic mdl_t mstep(mdl_t m_in, int w, bit st, bit v, logic [4:0] t,
                                 logic [31:0] c, logic [31:0] a);
    mdl_t        m;
    logic [31:0] mask;
    logic [31:0] tgt;
    bit          tk;
    m    = m_in;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    tgt  = a & mask & ~(32'(IB - 1));
    tk   = v && (t == `INSTR_JUMP) && ((c & mask) == 32'd1);
    if (!m.booted) begin
      m.booted = 1'b1;
    end else if (m.flush_left > 0) begin
      if (!st) m.flush_left = m.flush_left - 1;
    end else if (m.has_pend) begin
      if (!st) begin
        m.pc         = m.pend;
        m.has_pend   = 1'b0;
        m.flush_left = FC;
        if (m.count != 32'hFFFF_FFFF) m.count = m.count + 1;
      end
    end else if (tk) begin
      if (st) begin
        m.has_pend = 1'b1;
        m.pend     = tgt;
      end else begin
        m.pc         = tgt;
        m.flush_left = FC;
        if (m.count != 32'hFFFF_FFFF) m.count = m.count + 1;
      end
    end else if (!st) begin
      m.pc = (m.pc + 32'(IB)) & mask;
    end
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("pc32",    pc32, m32.pc);
    check("valid32", {31'b0, valid32}, 32'(m32.booted && (m32.flush_left == 0)));
    check("flush32", {31'b0, flush32}, 32'(m32.flush_left > 0));
    check("pend32",  {31'b0, pend32},  32'(m32.has_pend));
    check("pc8",     {24'b0, pc8}, m8.pc);
    check("valid8",  {31'b0, valid8},  32'(m8.booted && (m8.flush_left == 0)));
    check("flush8",  {31'b0, flush8},  32'(m8.flush_left > 0));
    check("pend8",   {31'b0, pend8},   32'(m8.has_pend));
`ifdef PC_REDIRECT_COUNT_EN
    check("count32", cnt32, m32.count);
    check("count8",  cnt8,  m8.count);
`endif
  endtask

  task automatic cyc(input bit st, input bit v, input logic [4:0] t,
                     input logic [31:0] c, input logic [31:0] a);
    stall = st; rv = v; itype = t; jcond = c; jaddr = a;
    @(posedge clk);
    m32 = mstep(m32, 32, st, v, t, c, a);
    m8  = mstep(m8, 8, st, v, t, c, a);
    #1;
    n_cyc++;
    $display("cyc %0d st=%0b rv=%0b type=%0d cond=%h addr=%h | pc32=%h v=%0b fl=%0b pd=%0b | pc8=%h v=%0b fl=%0b pd=%0b",
             n_cyc, st, v, t, c, a, pc32, valid32, flush32, pend32, pc8, valid8, flush8, pend8);
    check_all();
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
  endtask

  int pend_cycles;
  bit          r_st, r_v;
  logic [4:0]  r_t;
  logic [31:0] r_c;

  initial begin
    m32 = mreset();
    m8  = mreset();

    // Reset state while rst_n is held low.
    #2;
    check_all();
    #10;
    rst_n = 1'b1;

    // Boot, then sequential fetch 0x0, 0x4, 0x8.
    idle();
    check("boot_pc", pc32, 32'h0);
    check("boot_valid", {31'b0, valid32}, 32'd1);
    idle();
    idle();
    check("seq_pc", pc32, 32'h8);

    // Taken jump to 0x103 from 0x8: aligned target 0x100, two flush cycles.
    cyc(1'b0, 1'b1, `INSTR_JUMP, 32'd1, 32'h103);
    check("jmp_pc", pc32, 32'h100);
    check("jmp_flush", {31'b0, flush32}, 32'd1);
    idle();
    idle();
    check("post_flush_pc", pc32, 32'h100);
    check("post_flush_valid", {31'b0, valid32}, 32'd1);
    idle();

    // Jump under stall, a younger jump during the stall must be dropped.
    pend_cycles = 0;
    cyc(1'b1, 1'b1, `INSTR_JUMP, 32'd1, 32'h200);
    pend_cycles += int'(pend32);
    cyc(1'b1, 1'b1, `INSTR_JUMP, 32'd1, 32'h300);
    pend_cycles += int'(pend32);
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 32'd0);
    pend_cycles += int'(pend32);
    idle();
    pend_cycles += int'(pend32);
    check("pending_cycles", 32'(pend_cycles), 32'd3);
    check("hold_release_pc", pc32, 32'h200);
    idle();
    idle();
    idle();

    // Not-taken cases: condition 2, all-ones, wrong type, and 0x101.
    cyc(1'b0, 1'b1, `INSTR_JUMP, 32'd2, 32'h500);
    cyc(1'b0, 1'b1, `INSTR_JUMP, 32'hFFFF_FFFF, 32'h500);
    cyc(1'b0, 1'b1, (`INSTR_JUMP ^ 5'd1), 32'd1, 32'h500);
    cyc(1'b0, 1'b1, `INSTR_JUMP, 32'h101, 32'h540);
    idle();
    idle();

    // Asynchronous reset during a flush window.
    cyc(1'b0, 1'b1, `INSTR_JUMP, 32'd1, 32'h400);
    rst_n = 1'b0;
    #1;
    m32 = mreset();
    m8  = mreset();
    check_all();
    check("async_pc", pc32, 32'h0);
    check("async_flush", {31'b0, flush32}, 32'd0);
    #3;
    rst_n = 1'b1;

    // 8-bit instance wraps from 0xFC to 0x00 after 64 increments.
    idle();
    for (int i = 0; i < 63; i++) idle();
    check("wrap8_pre", {24'b0, pc8}, 32'hFC);
    idle();
    check("wrap8_pc", {24'b0, pc8}, 32'h00);
    check("wrap8_valid", {31'b0, valid8}, 32'd1);

    // Three applied redirects after reset.
    for (int j = 0; j < 3; j++) begin
      cyc(1'b0, 1'b1, `INSTR_JUMP, 32'd1, 32'h1000 + 32'(j * 32'h40));
      idle();
      idle();
    end
`ifdef PC_REDIRECT_COUNT_EN
    check("count_three", cnt32, 32'd3);
`endif

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      r_st = ($urandom_range(0, 3) == 0);
      r_v  = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) r_t = `INSTR_JUMP;
      else r_t = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 5))
        0, 1, 2: r_c = 32'd1;
        3:       r_c = 32'd2;
        4:       r_c = 32'h101;
        default: r_c = $urandom;
      endcase
      cyc(r_st, r_v, r_t, r_c, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
